// File: rtl/layer1_psum_accumulator.sv
// Layer-1 partial-sum accumulator: sums TAPS beats of 8 signed channels, adds bias,
// applies optional ReLU and saturation, and holds the packed result under valid/ready.
module layer1_psum_accumulator #(
  parameter int TAPS   = 9,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                relu_en,
  input  logic [8*DATA_W-1:0] bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*DATA_W-1:0] in_psum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*DATA_W-1:0] out_data,
  output logic [3:0]          tap_cnt
);

  localparam int                      CH       = 8;
  localparam logic [3:0]              LAST_TAP = 4'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v,
                                                   input logic en);
    return (en && v[ACC_W-1]) ? '0 : v;
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [CH];
  logic signed [ACC_W-1:0] acc_d [CH];
  logic signed [ACC_W-1:0] sum_w [CH];
  logic [3:0]              tap_q, tap_d;
  logic                    out_valid_q, out_valid_d;
  logic [8*DATA_W-1:0]     out_data_q, out_data_d;
  logic                    accept;
  logic                    last_beat;

  // While a result is held, a new beat can only enter as the result drains.
  assign in_ready  = (state_q == ST_ACC) ? 1'b1 : out_ready;
  assign accept    = in_valid && in_ready;
  assign last_beat = (tap_q == LAST_TAP);

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    for (int k = 0; k < CH; k++) begin
      sum_w[k] = acc_q[k] + sext(in_psum[k*DATA_W +: DATA_W]);
    end

    // acc and tap count are already zero in HOLD, so a draining beat starts a fresh pixel.
    if (clear) begin
      state_d     = ST_ACC;
      tap_d       = '0;
      out_valid_d = 1'b0;
      for (int k = 0; k < CH; k++) acc_d[k] = '0;
    end else if (accept && last_beat) begin
      for (int k = 0; k < CH; k++) begin
        out_data_d[k*DATA_W +: DATA_W] =
          sat(relu(sum_w[k] + sext(bias[k*DATA_W +: DATA_W]), relu_en));
        acc_d[k] = '0;
      end
      tap_d       = '0;
      out_valid_d = 1'b1;
      state_d     = ST_HOLD;
    end else if (accept) begin
      for (int k = 0; k < CH; k++) acc_d[k] = sum_w[k];
      tap_d       = tap_q + 4'd1;
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end else if (state_q == ST_HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end
  end

  // Result register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      tap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < CH; k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < CH; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tap_cnt   = tap_q;

endmodule

// File: tb/tb_layer1_psum_accumulator.sv
// Self-checking bench for layer1_psum_accumulator: table-driven pixels, directed
// backpressure/clear/reset sequences and random pixels, all checked through a scoreboard.
module tb_layer1_psum_accumulator;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         relu_en = 1'b0;
  logic [127:0] bias = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_psum = '0;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   tap_cnt;

  logic man_rdy = 1'b1;
  logic rnd_rdy = 1'b1;
  logic rand_mode = 1'b0;
  assign out_ready = rand_mode ? rnd_rdy : man_rdy;

  layer1_psum_accumulator #(.TAPS(9), .DATA_W(16), .ACC_W(21)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .tap_cnt(tap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_rdy <= ($urandom_range(0, 3) != 0);
  end

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] sbq[$];
  logic [127:0] mon_held;
  bit           mon_hold = 1'b0;

  typedef struct {
    int ps[8];
    int bs[8];
    bit relu;
    int ex[8];
  } vec_t;
  vec_t vt[4];

  function automatic logic [127:0] pack(input int v[8]);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = v[k][15:0];
    return r;
  endfunction

  function automatic logic [127:0] rep(input int v);
    int a[8];
    for (int k = 0; k < 8; k++) a[k] = v;
    return pack(a);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat(input logic [127:0] p, input logic r);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_psum  = p;
    relu_en  = r;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pixel(input logic [127:0] p, input logic [127:0] b, input logic r,
                       input logic [127:0] ex, input int nb);
    bias = b;
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1) sbq.push_back(ex);
      beat(p, r);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0].ps = '{default: 100};
    vt[0].bs = '{default: 5};
    vt[0].relu = 1'b0;
    vt[0].ex = '{default: 905};
    vt[1].ps = '{-10, 30000, -30000, 0, 1, -1, 3641, -3641};
    vt[1].bs = '{0, 0, 0, 7, -32768, 32767, 0, 0};
    vt[1].relu = 1'b0;
    vt[1].ex = '{-90, 32767, -32768, 7, -32759, 32758, 32767, -32768};
    vt[2].ps = vt[1].ps;
    vt[2].bs = vt[1].bs;
    vt[2].relu = 1'b1;
    vt[2].ex = '{0, 32767, 0, 7, 0, 32758, 32767, 0};
    vt[3].ps = '{3640, -3640, 0, -1, 1000, 2, -2, 5000};
    vt[3].bs = '{7, -8, 0, 0, -9000, 3, 0, -1};
    vt[3].relu = 1'b0;
    vt[3].ex = '{32767, -32768, 0, -9, 0, 21, -18, 32767};

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mon_hold = 1'b0;
        end else begin
          if (mon_hold && out_valid) chk("hold_stable", out_data, mon_held);
          mon_hold = 1'b0;
          if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_out: got %h expected none", out_data);
            end else begin
              chk("result", out_data, sbq.pop_front());
            end
          end else if (out_valid) begin
            mon_held = out_data;
            mon_hold = 1'b1;
          end
        end
      end
    join_none

    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_tap_cnt", 128'(tap_cnt), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      pixel(pack(vt[i].ps), pack(vt[i].bs), vt[i].relu, pack(vt[i].ex), 9);
      @(negedge clk);
      chk("latency_out_valid", 128'(out_valid), 128'(1));
      step();
    end

    // Backpressure, then a beat entering as the result drains
    man_rdy = 1'b0;
    pixel(pack(vt[0].ps), pack(vt[0].bs), 1'b0, rep(905), 9);
    in_valid = 1'b1;
    in_psum  = pack(vt[0].ps);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_data", out_data, rep(905));
    end
    step();
    man_rdy = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_tap_cnt", 128'(tap_cnt), 128'(1));
    chk("drain_out_valid", 128'(out_valid), 128'(0));
    step();
    pixel(pack(vt[0].ps), pack(vt[0].bs), 1'b0, rep(905), 8);
    step();

    // Clear mid-pixel, with a beat offered in the clear cycle
    bias = '0;
    for (int i = 0; i < 4; i++) beat(rep(50), 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_psum  = rep(50);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_tap_cnt", 128'(tap_cnt), 128'(0));
    step();
    pixel(rep(1), '0, 1'b0, rep(9), 9);
    step();
    step();

    // Clear while a result is held
    man_rdy = 1'b0;
    pixel(rep(1), '0, 1'b0, rep(9), 9);
    @(negedge clk);
    chk("clrv_pre_valid", 128'(out_valid), 128'(1));
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("clrv_out_valid", 128'(out_valid), 128'(0));
    chk("clrv_data_kept", out_data, rep(9));
    step();
    man_rdy = 1'b1;

    // Asynchronous reset mid-pixel
    for (int i = 0; i < 6; i++) beat(rep(50), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_out_data", out_data, '0);
    chk("arst_tap_cnt", 128'(tap_cnt), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    pixel(rep(2), '0, 1'b0, rep(18), 9);
    step();

    // Random pixels with input gaps and random out_ready
    rand_mode = 1'b1;
    for (int n = 0; n < 6; n++) begin
      int s[8];
      int bv[8];
      int pv[8];
      int ex[8];
      bit r;
      r = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        bv[k] = int'($urandom_range(0, 65535)) - 32768;
        s[k]  = bv[k];
      end
      bias = pack(bv);
      for (int t = 0; t < 9; t++) begin
        for (int k = 0; k < 8; k++) begin
          pv[k] = int'($urandom_range(0, 65535)) - 32768;
          s[k]  = s[k] + pv[k];
        end
        if (t == 8) begin
          for (int k = 0; k < 8; k++) begin
            ex[k] = s[k];
            if (r && ex[k] < 0) ex[k] = 0;
            if (ex[k] > 32767) ex[k] = 32767;
            if (ex[k] < -32768) ex[k] = -32768;
          end
          sbq.push_back(pack(ex));
        end
        repeat ($urandom_range(0, 2)) step();
        beat(pack(pv), r);
      end
    end
    rand_mode = 1'b0;
    man_rdy   = 1'b1;
    for (int c = 0; c < 100 && sbq.size() != 0; c++) step();
    step();
    chk("scoreboard_empty", 128'(sbq.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
